// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the forward/hazard controller.
//   FWD_*   : forward-mux select encodings (2'b11 is never produced)
//   slot_t  : one shadow-pipeline entry {valid, rd, regwrite, memread}
//   fwd_sel : nearest-producer forward select for one source register
package hazard_pkg;

  // Register-index width carried in a slot.
  localparam int RD_W = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } slot_t;

  // The EX slot is checked first: that producer is the nearer one once the
  // consumer reaches EX, so it must win over the older MEM producer.
  function automatic logic [1:0] fwd_sel(input logic [RD_W-1:0] src,
                                         input slot_t ex,
                                         input slot_t mem);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (src != '0) begin
      if (ex.valid && ex.regwrite && (ex.rd == src)) begin
        sel = FWD_MEM;
      end else if (mem.valid && mem.regwrite && (mem.rd == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// hazard_slot_pipe: three-entry shadow of destination-register info that
// tracks the instructions sitting in EX, MEM and WB.
//   clk, rst   : clock, synchronous active-high reset (all slots invalid)
//   hold       : freeze every slot
//   id_slot_i  : entry entering EX on advance (caller passes '0 for a bubble)
//   ex_o/mem_o/wb_o : current slot contents
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  slot_t id_slot_i,
  output slot_t ex_o,
  output slot_t mem_o,
  output slot_t wb_o
);

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;

  // The entry leaving WB is simply overwritten: the register file is
  // write-through, so nothing downstream of WB needs tracking.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      ex_d  = id_slot_i;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl: operand-forward selects and load-use stall for a
// 5-stage pipeline. Compares the ID-stage sources against a shadow of the
// EX/MEM producers and registers the selects alongside the ID/EX register.
//   iClk, iReset         : clock, synchronous active-high reset
//   iHold                : global freeze (slots and cmd registers hold)
//   iFlush               : squash the ID instruction (bubble into EX)
//   iIdValid/Rs/Rt/Rd    : ID instruction and its register indices
//   iIdRegWrite/MemRead  : ID instruction writes the regfile / is a load
//   oForwardCmdA/B       : 00 regfile, 01 from MEM, 10 from WB
//   oStall               : combinational load-use stall (one cycle)
//   oStallCount/oFwdCount: saturating statistics, present only when the
//                          HAZARD_STATS_EN macro is defined
// REG_ADDR_W must equal hazard_pkg::RD_W, the index width stored in a slot.
module forward_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = RD_W
`ifdef HAZARD_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iHold,
  input  logic                  iFlush,
  input  logic                  iIdValid,
  input  logic [REG_ADDR_W-1:0] iIdRs,
  input  logic [REG_ADDR_W-1:0] iIdRt,
  input  logic [REG_ADDR_W-1:0] iIdRd,
  input  logic                  iIdRegWrite,
  input  logic                  iIdMemRead,
  output logic [1:0]            oForwardCmdA,
  output logic [1:0]            oForwardCmdB,
  output logic                  oStall
`ifdef HAZARD_STATS_EN
  , output logic [STAT_W-1:0]   oStallCount
  , output logic [STAT_W-1:0]   oFwdCount
`endif
);

  slot_t ex_slot, mem_slot, wb_slot_unused;
  slot_t id_slot;
  logic  stall;
  logic  bubble;
  logic [1:0] cmd_a_q, cmd_a_d;
  logic [1:0] cmd_b_q, cmd_b_d;

  hazard_slot_pipe u_slot_pipe (
    .clk       (iClk),
    .rst       (iReset),
    .hold      (iHold),
    .id_slot_i (id_slot),
    .ex_o      (ex_slot),
    .mem_o     (mem_slot),
    .wb_o      (wb_slot_unused)
  );

  // A load in EX cannot forward yet; hold the consumer in ID for one cycle.
  // The bubble that follows clears EX.memread, so the stall cannot repeat.
  // When ID does not advance into EX (flush, stall, no instruction) the
  // entry and its selects are zeroed, so a bubble never carries a forward.
  always_comb begin
    stall = iIdValid && ex_slot.valid && ex_slot.memread && (ex_slot.rd != '0) &&
            ((ex_slot.rd == iIdRs) || (ex_slot.rd == iIdRt));
    bubble  = iFlush || stall || !iIdValid;
    id_slot = '0;
    cmd_a_d = cmd_a_q;
    cmd_b_d = cmd_b_q;
    if (!bubble) begin
      id_slot.valid    = 1'b1;
      id_slot.rd       = iIdRd;
      id_slot.regwrite = iIdRegWrite;
      id_slot.memread  = iIdMemRead;
    end
    if (!iHold) begin
      cmd_a_d = bubble ? FWD_NONE : fwd_sel(iIdRs, ex_slot, mem_slot);
      cmd_b_d = bubble ? FWD_NONE : fwd_sel(iIdRt, ex_slot, mem_slot);
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      cmd_a_q <= FWD_NONE;
      cmd_b_q <= FWD_NONE;
    end else begin
      cmd_a_q <= cmd_a_d;
      cmd_b_q <= cmd_b_d;
    end
  end

  assign oForwardCmdA = cmd_a_q;
  assign oForwardCmdB = cmd_b_q;
  assign oStall       = stall;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]        fwd_inc;
  logic [STAT_W:0]   fwd_sum;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    fwd_inc     = {1'b0, (cmd_a_d != FWD_NONE)} + {1'b0, (cmd_b_d != FWD_NONE)};
    fwd_sum     = {1'b0, fwd_cnt_q} + {{(STAT_W-1){1'b0}}, fwd_inc};
    if (!iHold) begin
      if (stall && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
      end
      fwd_cnt_d = fwd_sum[STAT_W] ? '1 : fwd_sum[STAT_W-1:0];
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign oStallCount = stall_cnt_q;
  assign oFwdCount   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// tb_forward_hazard_ctrl: table-driven bench for forward_hazard_ctrl.
// Each record is one ID-stage cycle: the combinational stall is checked in
// that cycle, the expected registered selects are queued and compared after
// the clock edge. Statistics checks compile only with HAZARD_STATS_EN.
module tb_forward_hazard_ctrl;

  // ---------------- clock / reset / DUT ----------------
  logic       iClk = 1'b0;
  logic       iReset, iHold, iFlush, iIdValid, iIdRegWrite, iIdMemRead;
  logic [4:0] iIdRs, iIdRt, iIdRd;
  logic [1:0] oForwardCmdA, oForwardCmdB;
  logic       oStall;
`ifdef HAZARD_STATS_EN
  logic [31:0] oStallCount, oFwdCount;
`endif

  always #5 iClk = ~iClk;

  forward_hazard_ctrl dut (
    .iClk         (iClk),
    .iReset       (iReset),
    .iHold        (iHold),
    .iFlush       (iFlush),
    .iIdValid     (iIdValid),
    .iIdRs        (iIdRs),
    .iIdRt        (iIdRt),
    .iIdRd        (iIdRd),
    .iIdRegWrite  (iIdRegWrite),
    .iIdMemRead   (iIdMemRead),
    .oForwardCmdA (oForwardCmdA),
    .oForwardCmdB (oForwardCmdB),
    .oStall       (oStall)
`ifdef HAZARD_STATS_EN
    , .oStallCount(oStallCount)
    , .oFwdCount  (oFwdCount)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, hold, flush, valid, mr;
    logic [4:0] rs, rt, rd;
    logic       exp_stall;
    logic [1:0] exp_a, exp_b;
    logic       chk_cnt;
    int         exp_sc, exp_fc;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic push(input logic rst, hold, flush, valid, mr,
                      input logic [4:0] rs, rt, rd,
                      input logic st, input logic [1:0] ea, eb,
                      input logic cc, input int sc, fc);
    vec_t v;
    v.rst = rst; v.hold = hold; v.flush = flush; v.valid = valid; v.mr = mr;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.exp_stall = st; v.exp_a = ea; v.exp_b = eb;
    v.chk_cnt = cc; v.exp_sc = sc; v.exp_fc = fc;
    tbl.push_back(v);
  endtask

  // Real instruction (ALU op or load; both write the register file).
  task automatic op(input logic [4:0] rs, rt, rd, input logic mr,
                    input logic st, input logic [1:0] ea, eb,
                    input logic hold = 1'b0, flush = 1'b0, rst = 1'b0);
    push(rst, hold, flush, 1'b1, mr, rs, rt, rd, st, ea, eb, 1'b0, 0, 0);
  endtask

  // Empty ID slot; its register fields are randomised when applied.
  task automatic nop(input logic hold = 1'b0, rst = 1'b0,
                     input logic [1:0] ea = 2'b00, eb = 2'b00,
                     input logic cc = 1'b0, input int sc = 0, fc = 0);
    push(rst, hold, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, ea, eb, cc, sc, fc);
  endtask

  task automatic apply(input int idx, input vec_t v);
    logic [3:0] e;
    @(negedge iClk);
    iReset   = v.rst;
    iHold    = v.hold;
    iFlush   = v.flush;
    iIdValid = v.valid;
    if (v.valid) begin
      iIdRs = v.rs; iIdRt = v.rt; iIdRd = v.rd;
      iIdRegWrite = 1'b1; iIdMemRead = v.mr;
    end else begin
      iIdRs = 5'($urandom_range(0, 31));
      iIdRt = 5'($urandom_range(0, 31));
      iIdRd = 5'($urandom_range(0, 31));
      iIdRegWrite = 1'($urandom_range(0, 1));
      iIdMemRead  = 1'($urandom_range(0, 1));
    end
    exp_q.push_back({v.exp_a, v.exp_b});
    #1;
    check("stall", idx, {31'd0, oStall}, {31'd0, v.exp_stall});
    @(posedge iClk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", idx, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("cmd_a", idx, {30'd0, oForwardCmdA}, {30'd0, e[3:2]});
      check("cmd_b", idx, {30'd0, oForwardCmdB}, {30'd0, e[1:0]});
    end
`ifdef HAZARD_STATS_EN
    if (v.chk_cnt) begin
      check("stall_count", idx, oStallCount, v.exp_sc);
      check("fwd_count", idx, oFwdCount, v.exp_fc);
    end
`endif
  endtask

  initial begin
    iReset = 1'b1; iHold = 1'b0; iFlush = 1'b0; iIdValid = 1'b0;
    iIdRs = '0; iIdRt = '0; iIdRd = '0; iIdRegWrite = 1'b0; iIdMemRead = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge iClk);
    #1;
    check("reset_stall", -1, {31'd0, oStall}, 32'd0);
    check("reset_cmd_a", -1, {30'd0, oForwardCmdA}, 32'd0);
    check("reset_cmd_b", -1, {30'd0, oForwardCmdB}, 32'd0);
`ifdef HAZARD_STATS_EN
    check("reset_stall_count", -1, oStallCount, 0);
    check("reset_fwd_count", -1, oFwdCount, 0);
`endif

    // ---- table ----
    // add r3<-r1,r2 ; add r4<-r3,r5 : EX producer -> A from MEM
    op(1, 2, 3, 0, 0, 2'b00, 2'b00);
    op(3, 5, 4, 0, 0, 2'b01, 2'b00);
    nop(); nop(); nop();
    // add r3 ; nop ; sub r6<-r5,r3 : MEM producer -> B from WB
    op(1, 2, 3, 0, 0, 2'b00, 2'b00);
    nop();
    op(5, 3, 6, 0, 0, 2'b00, 2'b10);
    nop(); nop();
    // add r7 ; add r7 ; or r8<-r7,r7 : nearer producer wins on both
    op(1, 2, 7, 0, 0, 2'b00, 2'b00);
    op(1, 2, 7, 0, 0, 2'b00, 2'b00);
    op(7, 7, 8, 0, 0, 2'b01, 2'b01);
    nop(); nop();
    // producers writing r0 never forward or stall
    op(1, 2, 0, 0, 0, 2'b00, 2'b00);
    op(0, 0, 9, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    op(1, 0, 0, 1, 0, 2'b00, 2'b00);
    op(0, 0, 9, 0, 0, 2'b00, 2'b00);
    nop(); nop();
    // load-use after a reset: one stall, bubble, then both from WB
    nop(.rst(1'b1));
    op(1, 0, 2, 1, 0, 2'b00, 2'b00);
    op(2, 2, 4, 0, 1, 2'b00, 2'b00);
    op(2, 2, 4, 0, 0, 2'b10, 2'b10);
    nop();
    nop(.cc(1'b1), .sc(1), .fc(2));
    // hold for 3 cycles in the middle of the forward sequence
    op(1, 2, 3, 0, 0, 2'b00, 2'b00);
    op(3, 5, 4, 0, 0, 2'b01, 2'b00);
    nop(.hold(1'b1), .ea(2'b01));
    nop(.hold(1'b1), .ea(2'b01));
    nop(.hold(1'b1), .ea(2'b01));
    nop(); nop();
    // hold while a load-use stall is pending: stall stays, counted once
    op(1, 0, 2, 1, 0, 2'b00, 2'b00);
    op(2, 2, 4, 0, 1, 2'b00, 2'b00, .hold(1'b1));
    op(2, 2, 4, 0, 1, 2'b00, 2'b00, .hold(1'b1));
    op(2, 2, 4, 0, 1, 2'b00, 2'b00);
    op(2, 2, 4, 0, 0, 2'b10, 2'b10);
    nop();
    nop(.cc(1'b1), .sc(2), .fc(5));
    // flush together with stall: bubble, and no second stall
    op(1, 0, 2, 1, 0, 2'b00, 2'b00);
    op(2, 2, 4, 0, 1, 2'b00, 2'b00, .flush(1'b1));
    op(2, 6, 5, 0, 0, 2'b10, 2'b00);
    nop();
    nop(.cc(1'b1), .sc(3), .fc(6));
    // reset while the load-use stall is active
    op(1, 0, 2, 1, 0, 2'b00, 2'b00);
    op(2, 2, 4, 0, 1, 2'b00, 2'b00, .rst(1'b1));
    op(2, 2, 4, 0, 0, 2'b00, 2'b00);
    nop(.cc(1'b1), .sc(0), .fc(0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(i, tbl[i]);
    end

    if (exp_q.size() != 0) begin
      check("scoreboard_leftover", -1, exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
